// File: rtl/xike_sync_pkg.sv
// Shared types, default frame timings and width helper for the frame-timed
// sync barcode generator family.
package xike_sync_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      GAP,
      BIT,
      PAR
   } sync_state_t;

   localparam int FS_DEFAULT           = 25000;
   localparam int SEC_W_DEFAULT        = 12;
   localparam int START_FRAMES_DEFAULT = 2500;
   localparam int GAP_FRAMES_DEFAULT   = 500;
   localparam int BIT_FRAMES_DEFAULT   = 1000;
   localparam int ONE_FRAMES_DEFAULT   = 600;
   localparam int ZERO_FRAMES_DEFAULT  = 200;

   // Counter width able to hold 0..frames-1, never narrower than one bit.
   function automatic int frames_w(input int frames);
      return (frames > 1) ? $clog2(frames) : 1;
   endfunction

endpackage

// File: rtl/sync_barcode_gen_frame_strobe_det.sv
// Turns toggles of the frame number LSB into a one-cycle frame strobe:
// two capture stages, their XOR registered once more.
module frame_strobe_det (
   input  logic clk,
   input  logic rst,
   input  logic frame_bit,
   output logic strobe
);

   logic stage0_reg;
   logic stage1_reg;
   logic strobe_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage0_reg <= 1'b0;
         stage1_reg <= 1'b0;
         strobe_reg <= 1'b0;
      end else begin
         stage0_reg <= frame_bit;
         stage1_reg <= stage0_reg;
         strobe_reg <= stage0_reg ^ stage1_reg;
      end
   end

   assign strobe = strobe_reg;

endmodule

// File: rtl/sync_barcode_gen.sv
// Seconds timebase from frame toggles plus a pulse-width barcode of the
// seconds count on sync_pulse. Define SYNC_PARITY_EN to append a parity slot.
module sync_barcode_gen
   import xike_sync_pkg::*;
#(
   parameter int FS           = FS_DEFAULT,
   parameter int SEC_W        = SEC_W_DEFAULT,
   parameter int START_FRAMES = START_FRAMES_DEFAULT,
   parameter int GAP_FRAMES   = GAP_FRAMES_DEFAULT,
   parameter int BIT_FRAMES   = BIT_FRAMES_DEFAULT,
   parameter int ONE_FRAMES   = ONE_FRAMES_DEFAULT,
   parameter int ZERO_FRAMES  = ZERO_FRAMES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      frame_No,
   output logic [SEC_W-1:0] sec,
   output logic             sec_vld,
   output logic             sync_pulse,
   output logic             busy
);

`ifdef SYNC_PARITY_EN
   localparam int PAR_SLOTS = 1;
`else
   localparam int PAR_SLOTS = 0;
`endif

   localparam int MAX_FRAMES = (START_FRAMES > GAP_FRAMES)
                             ? ((START_FRAMES > BIT_FRAMES) ? START_FRAMES : BIT_FRAMES)
                             : ((GAP_FRAMES > BIT_FRAMES) ? GAP_FRAMES : BIT_FRAMES);
   localparam int CNT_W = frames_w(FS);
   localparam int DUR_W = frames_w(MAX_FRAMES);
   localparam int IDX_W = frames_w(SEC_W);

   generate
      if (!(ONE_FRAMES < BIT_FRAMES && ZERO_FRAMES < ONE_FRAMES && ZERO_FRAMES >= 1 &&
            START_FRAMES + GAP_FRAMES + (SEC_W + PAR_SLOTS) * BIT_FRAMES < FS)) begin : g_bad_timing
         $error("sync_barcode_gen: barcode timing does not fit one second");
      end
   endgenerate

   logic strobe;
   logic unused_frame_hi;

   assign unused_frame_hi = ^frame_No[31:1];

   frame_strobe_det u_strobe (
      .clk       (clk),
      .rst       (rst),
      .frame_bit (frame_No[0]),
      .strobe    (strobe)
   );

   // Seconds timebase; armed_reg issues the sec=0 marker right after reset.
   logic [CNT_W-1:0] cnt_reg;
   logic [SEC_W-1:0] sec_reg;
   logic             sec_vld_reg;
   logic             armed_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg     <= '0;
         sec_reg     <= '0;
         sec_vld_reg <= 1'b0;
         armed_reg   <= 1'b1;
      end else begin
         sec_vld_reg <= armed_reg;
         armed_reg   <= 1'b0;
         if (strobe) begin
            if (cnt_reg == CNT_W'(FS - 1)) begin
               cnt_reg     <= '0;
               sec_reg     <= sec_reg + 1'b1;
               sec_vld_reg <= 1'b1;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
      end
   end

   sync_state_t      state_reg;
   logic [SEC_W-1:0] shift_reg;
   logic [DUR_W-1:0] dur_reg;
   logic [IDX_W-1:0] idx_reg;
   logic             sync_reg;
   logic             busy_reg;
   logic             slot_bit;
   logic [DUR_W-1:0] high_frames;
   logic [DUR_W-1:0] dur_next;
`ifdef SYNC_PARITY_EN
   logic             par_reg;
`endif

   always_comb begin
      slot_bit = shift_reg[0];
`ifdef SYNC_PARITY_EN
      if (state_reg == PAR) slot_bit = par_reg;
`endif
      high_frames = slot_bit ? DUR_W'(ONE_FRAMES) : DUR_W'(ZERO_FRAMES);
      dur_next    = dur_reg + 1'b1;
   end

   // Every duration advances on frame strobes only; the strobe coinciding
   // with the IDLE->START hand-over is deliberately not counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         dur_reg   <= '0;
         idx_reg   <= '0;
         sync_reg  <= 1'b0;
         busy_reg  <= 1'b0;
`ifdef SYNC_PARITY_EN
         par_reg   <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (sec_vld_reg) begin
                  state_reg <= START;
                  shift_reg <= sec_reg;
                  dur_reg   <= '0;
                  idx_reg   <= '0;
                  sync_reg  <= 1'b1;
                  busy_reg  <= 1'b1;
`ifdef SYNC_PARITY_EN
                  par_reg   <= ^sec_reg;
`endif
               end
            end
            START: begin
               if (strobe) begin
                  if (dur_reg == DUR_W'(START_FRAMES - 1)) begin
                     state_reg <= GAP;
                     dur_reg   <= '0;
                     sync_reg  <= 1'b0;
                  end else begin
                     dur_reg <= dur_next;
                  end
               end
            end
            GAP: begin
               if (strobe) begin
                  if (dur_reg == DUR_W'(GAP_FRAMES - 1)) begin
                     state_reg <= BIT;
                     dur_reg   <= '0;
                     idx_reg   <= '0;
                     sync_reg  <= 1'b1;
                  end else begin
                     dur_reg <= dur_next;
                  end
               end
            end
            BIT: begin
               if (strobe) begin
                  if (dur_reg == DUR_W'(BIT_FRAMES - 1)) begin
                     dur_reg   <= '0;
                     shift_reg <= shift_reg >> 1;
                     if (idx_reg == IDX_W'(SEC_W - 1)) begin
`ifdef SYNC_PARITY_EN
                        state_reg <= PAR;
                        sync_reg  <= 1'b1;
`else
                        state_reg <= IDLE;
                        sync_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
`endif
                     end else begin
                        idx_reg  <= idx_reg + 1'b1;
                        sync_reg <= 1'b1;
                     end
                  end else begin
                     dur_reg  <= dur_next;
                     sync_reg <= (dur_next < high_frames);
                  end
               end
            end
`ifdef SYNC_PARITY_EN
            PAR: begin
               if (strobe) begin
                  if (dur_reg == DUR_W'(BIT_FRAMES - 1)) begin
                     state_reg <= IDLE;
                     dur_reg   <= '0;
                     sync_reg  <= 1'b0;
                     busy_reg  <= 1'b0;
                  end else begin
                     dur_reg  <= dur_next;
                     sync_reg <= (dur_next < high_frames);
                  end
               end
            end
`endif
            default: begin
               state_reg <= IDLE;
               sync_reg  <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign sec        = sec_reg;
   assign sec_vld    = sec_vld_reg;
   assign sync_pulse = sync_reg;
   assign busy       = busy_reg;

endmodule
